// File: rtl/output_bank_sequencer.sv
// Output bank sequencer: runs the output store one frame at a time, ping-ponging
// frames between two halves of output memory and tracking which halves hold
// frames the downstream consumer has not yet freed.
module output_bank_sequencer #(
  parameter int unsigned WORDS_PER_FRAME = 2048,
  parameter int unsigned CNT_W           = 12
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_req,
  output logic       frame_ack,
  output logic       store_start,
  output logic       store_bank,
  input  logic       store_we,
  input  logic       store_done,
  output logic [1:0] bank_full,
  input  logic [1:0] bank_release,
  output logic       frame_done,
  output logic       release_err
);

  localparam int unsigned NUM_BANKS = 2;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     word_cnt;
  logic                 next_bank;
  logic                 frame_end_c;
  logic [NUM_BANKS-1:0] set_mask_c;

  // Last word of the frame is being written on this edge.
  assign frame_end_c = (state == RUN) && store_we && (word_cnt == LAST_WORD);

  // Bank that the completing frame marks as full (empty when no frame completes).
  assign set_mask_c = {frame_end_c & store_bank, frame_end_c & ~store_bank};

  // Frame sequencing: accept a request into a free bank, count store words, drain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      store_start <= 1'b0;
      store_bank  <= 1'b0;
      frame_ack   <= 1'b0;
      frame_done  <= 1'b0;
      word_cnt    <= '0;
      next_bank   <= 1'b0;
    end else begin
      frame_ack  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_req) state <= ARM;
        end
        ARM: begin
          if (!frame_req) begin
            state <= IDLE;
          end else if (!bank_full[next_bank] && store_done) begin
            store_bank  <= next_bank;
            frame_ack   <= 1'b1;
            store_start <= 1'b1;
            word_cnt    <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (store_we) begin
            if (frame_end_c) begin
              store_start <= 1'b0;
              frame_done  <= 1'b1;
              next_bank   <= ~store_bank;
              state       <= DRAIN;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (store_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bank occupancy: frame completion sets, consumer release clears, set wins a tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bank_full   <= '0;
      release_err <= 1'b0;
    end else begin
      bank_full <= (bank_full & ~(bank_release & ~set_mask_c)) | set_mask_c;
      if (|(bank_release & (set_mask_c | ~bank_full))) release_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_bank_sequencer.sv
// Bench for output_bank_sequencer: directed scenarios plus random traffic,
// checked every cycle against a frame-level reference model.
module tb_output_bank_sequencer;

  localparam int unsigned WPF   = 2;
  localparam int unsigned CNT_W = 1;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       frame_req;
  logic       frame_ack;
  logic       store_start;
  logic       store_bank;
  logic       store_we;
  logic       store_done = 1'b1;
  logic [1:0] bank_full;
  logic [1:0] bank_release;
  logic       frame_done;
  logic       release_err;

  logic st_we = 1'b0;
  logic spur_we;
  int   st_cnt = 0;

  int n_cmp = 0;
  int n_bad = 0;

  output_bank_sequencer #(.WORDS_PER_FRAME(WPF), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .frame_req    (frame_req),
    .frame_ack    (frame_ack),
    .store_start  (store_start),
    .store_bank   (store_bank),
    .store_we     (store_we),
    .store_done   (store_done),
    .bank_full    (bank_full),
    .bank_release (bank_release),
    .frame_done   (frame_done),
    .release_err  (release_err)
  );

  always #5 clock = ~clock;

  assign store_we = st_we | spur_we;

  // Store model: one word every 16 cycles of store_start; idle (done) when not started.
  always @(posedge clock) begin
    #1;
    if (store_start) begin
      st_cnt     = st_cnt + 1;
      st_we      = ((st_cnt % 16) == 0);
      store_done = 1'b0;
    end else begin
      st_cnt     = 0;
      st_we      = 1'b0;
      store_done = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_WRITE = 2, PH_FLUSH = 3;
  int         m_phase;
  int         m_words;
  logic       m_bank, m_next, m_ack, m_done, m_start, m_err;
  logic [1:0] m_full;
  logic       m_fin;
  logic [1:0] m_set;
  logic [2:0] m_rel;

  // Release outcome per bank: {error, new occupancy}.
  function automatic logic [2:0] rel_result(logic [1:0] full, logic [1:0] rel, logic [1:0] set);
    logic [1:0] f;
    logic       e;
    f = full | set;
    e = 1'b0;
    for (int b = 0; b < 2; b++) begin
      if (rel[b]) begin
        if (set[b] || !full[b]) e = 1'b1;
        else f[b] = 1'b0;
      end
    end
    return {e, f};
  endfunction

  assign m_fin = (m_phase == PH_WRITE) && store_we && (m_words == int'(WPF) - 1);
  assign m_set = m_fin ? (m_bank ? 2'b10 : 2'b01) : 2'b00;
  assign m_rel = rel_result(m_full, bank_release, m_set);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= PH_IDLE;
      m_words <= 0;
      m_bank  <= 1'b0;
      m_next  <= 1'b0;
      m_ack   <= 1'b0;
      m_done  <= 1'b0;
      m_start <= 1'b0;
      m_err   <= 1'b0;
      m_full  <= 2'b00;
    end else begin
      m_ack  <= 1'b0;
      m_done <= 1'b0;
      m_full <= m_rel[1:0];
      m_err  <= m_err | m_rel[2];
      if (m_phase == PH_IDLE && frame_req) m_phase <= PH_WAIT;
      if (m_phase == PH_WAIT) begin
        if (!frame_req) m_phase <= PH_IDLE;
        else if (!m_full[m_next] && store_done) begin
          m_bank  <= m_next;
          m_ack   <= 1'b1;
          m_start <= 1'b1;
          m_words <= 0;
          m_phase <= PH_WRITE;
        end
      end
      if (m_phase == PH_WRITE && store_we) begin
        if (m_fin) begin
          m_start <= 1'b0;
          m_done  <= 1'b1;
          m_next  <= !m_bank;
          m_phase <= PH_FLUSH;
        end else begin
          m_words <= m_words + 1;
        end
      end
      if (m_phase == PH_FLUSH && store_done) m_phase <= PH_IDLE;
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  always @(negedge clock) begin
    check("frame_ack",   32'(frame_ack),   32'(m_ack));
    check("store_start", 32'(store_start), 32'(m_start));
    check("store_bank",  32'(store_bank),  32'(m_bank));
    check("bank_full",   32'(bank_full),   32'(m_full));
    check("frame_done",  32'(frame_done),  32'(m_done));
    check("release_err", 32'(release_err), 32'(m_err));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    frame_req    = 1'b0;
    bank_release = 2'b00;
    spur_we      = 1'b0;
    #1;
    check("rst_store_start", 32'(store_start), 32'd0);
    check("rst_bank_full",   32'(bank_full),   32'd0);
    check("rst_release_err", 32'(release_err), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_ack();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (frame_ack) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("ack_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("done_timeout", 32'(ok), 32'd1);
  endtask

  // Request a frame, expect it on exp_bank, return the number of store_start cycles.
  task automatic run_frame(input logic exp_bank, output int cycles);
    frame_req = 1'b1;
    wait_ack();
    check("ack_bank", 32'(store_bank), 32'(exp_bank));
    frame_req = 1'b0;
    cycles = 0;
    while (store_start && cycles < 200) begin
      cycles++;
      tick();
    end
    check("frame_done_at_end", 32'(frame_done), 32'd1);
  endtask

  initial begin
    int  cyc;
    int  seen;
    bit  saw;
    reset_n      = 1'b1;
    frame_req    = 1'b0;
    bank_release = 2'b00;
    spur_we      = 1'b0;
    #1;

    // 1: single frame on bank 0, 32 store_start cycles
    do_reset();
    frame_req = 1'b1;
    tick();
    check("t1_no_early_ack", 32'(frame_ack), 32'd0);
    tick();
    check("t1_ack", 32'(frame_ack), 32'd1);
    check("t1_bank", 32'(store_bank), 32'd0);
    frame_req = 1'b0;
    cyc = 0;
    while (store_start && cyc < 200) begin
      cyc++;
      tick();
    end
    check("t1_start_cycles", 32'(cyc), 32'd32);
    check("t1_frame_done", 32'(frame_done), 32'd1);
    check("t1_bank_full", 32'(bank_full), 32'h1);

    // 2: three frames with no release; third stalls until bank 0 is freed
    do_reset();
    run_frame(1'b0, cyc);
    tick();
    run_frame(1'b1, cyc);
    check("t2_full_both", 32'(bank_full), 32'h3);
    frame_req = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      saw |= frame_ack;
    end
    check("t2_stall_no_ack", 32'(saw), 32'd0);
    bank_release = 2'b01;
    tick();
    bank_release = 2'b00;
    check("t2_after_release", 32'(bank_full), 32'h2);
    check("t2_ack_not_yet", 32'(frame_ack), 32'd0);
    tick();
    check("t2_third_ack", 32'(frame_ack), 32'd1);
    check("t2_third_bank", 32'(store_bank), 32'd0);
    frame_req = 1'b0;
    wait_done();
    check("t2_full_end", 32'(bank_full), 32'h3);
    tick();

    // 3: releasing an empty bank
    do_reset();
    bank_release = 2'b10;
    tick();
    bank_release = 2'b00;
    check("t3_err", 32'(release_err), 32'd1);
    check("t3_full", 32'(bank_full), 32'h0);

    // 4: release of bank 1 on the same edge its frame completes
    do_reset();
    run_frame(1'b0, cyc);
    tick();
    frame_req = 1'b1;
    wait_ack();
    frame_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (store_we) begin
        seen++;
        if (seen == 2) break;
      end
      tick();
    end
    check("t4_we_seen", 32'(seen), 32'd2);
    bank_release = 2'b10;
    tick();
    bank_release = 2'b00;
    check("t4_done", 32'(frame_done), 32'd1);
    check("t4_full", 32'(bank_full), 32'h3);
    check("t4_err", 32'(release_err), 32'd1);
    tick();

    // 5: reset in the middle of a frame
    do_reset();
    run_frame(1'b0, cyc);
    tick();
    frame_req = 1'b1;
    wait_ack();
    frame_req = 1'b0;
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    check("t5_start_drop", 32'(store_start), 32'd0);
    check("t5_full_clear", 32'(bank_full), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    run_frame(1'b0, cyc);
    check("t5_restart_cycles", 32'(cyc), 32'd32);
    tick();

    // 6: spurious store_we outside RUN does not disturb the word count
    spur_we = 1'b1;
    repeat (3) tick();
    spur_we = 1'b0;
    run_frame(1'b1, cyc);
    check("t6_cycles", 32'(cyc), 32'd32);
    check("t6_no_err", 32'(release_err), 32'd0);
    tick();

    // random traffic checked by the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (frame_req && frame_ack) frame_req = 1'b0;
      else if (!frame_req && $urandom_range(7) == 0) frame_req = 1'b1;
      else if (frame_req && !store_start && $urandom_range(39) == 0) frame_req = 1'b0;
      bank_release = ($urandom_range(15) == 0) ? 2'($urandom_range(3)) : 2'b00;
      spur_we = !store_start && ($urandom_range(9) == 0);
      if ($urandom_range(1499) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
      tick();
    end
    bank_release = 2'b00;
    spur_we      = 1'b0;
    frame_req    = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
